uart_tx_param: RTL and testbench

Parametrised UART transmitter with an integrated baud divider, replacing the fixed 8N1 transmitter. Frame format is runtime-configurable: 5–9 data bits, none/odd/even/mark/space parity, and 1 or 2 stop bits. It also supports break generation. Sits between the TX FIFO (valid/ready source) and the serial pin, all in the single system clock domain.

---
 rtl/uart_tx_param_if.sv | 14 +
 rtl/uart_tx_param.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_param.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_param_if.sv
// Payload handshake between the TX FIFO (master) and the UART transmitter (slave).
//   s_data  : frame payload, LSB first
//   s_valid : payload valid (from the FIFO)
//   s_ready : the transmitter takes the payload this cycle
interface uart_tx_param_if #(
   parameter int MAX_DATA_BITS = 9
);
   logic [MAX_DATA_BITS-1:0] s_data;
   logic                     s_valid;
   logic                     s_ready;

   modport master (output s_data, output s_valid, input  s_ready);
   modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_param.sv
// UART transmitter with a runtime-configurable frame format and an integrated baud divider.
// Frame: start, 5..MAX_DATA_BITS data bits (LSB first), optional parity, then 1 or 2 stop bits.
// A break condition can also be driven on the line.
// Ports:
//   clk, rst_n        system clock; asynchronous active-low reset
//   tx_en             gates the acceptance of new frames only
//   div               bit period = div+1 clocks (latched at accept; used live for the break release)
//   data_bits         5..MAX_DATA_BITS selects the data-bit count; any other value gives 8
//   parity            000 none, 001 odd, 010 even, 011 mark, 100 space; any other value gives none
//   stop_bits         0 = one stop bit, 1 = two stop bits
//   send_break        holds the line low while asserted in IDLE
//   s_if              payload handshake (slave side)
//   tx                serial line, idle high
//   tx_busy           high whenever the state is not IDLE
//   tx_done           one-cycle pulse when a frame or a break completes
module uart_tx_param #(
   parameter int MAX_DATA_BITS = 9,
   parameter int DIV_WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tx_en,
   input  logic [DIV_WIDTH-1:0] div,
   input  logic [3:0]           data_bits,
   input  logic [2:0]           parity,
   input  logic                 stop_bits,
   input  logic                 send_break,
   uart_tx_param_if.slave       s_if,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

   state_t                   state;
   logic [DIV_WIDTH-1:0]     cnt;
   logic [DIV_WIDTH-1:0]     div_l;
   logic [3:0]               nb_l;
   logic [3:0]               bit_idx;
   logic [MAX_DATA_BITS-1:0] shreg;
   logic                     par_on_l;
   logic                     par_bit_l;
   logic                     stop2_l;
   logic                     stop_idx;
   logic                     brk_rel;   // break released: sending the closing idle bit

   logic [3:0]               nb_in;
   logic [MAX_DATA_BITS-1:0] used;
   logic                     par_on;
   logic                     par_val;
   logic                     bit_end;
   logic                     accept;

   // The rst_n term keeps s_ready low while reset is held, even though IDLE is the reset state.
   assign s_if.s_ready = (state == IDLE) && tx_en && !send_break && rst_n;
   assign accept       = s_if.s_valid && s_if.s_ready;
   assign bit_end      = (cnt == div_l);

   // Frame setup from the live config. It is captured only on accept.
   always_comb begin
      nb_in = 4'd8;
      if (data_bits >= 4'd5 && int'(data_bits) <= MAX_DATA_BITS) nb_in = data_bits;
      used = '0;
      for (int i = 0; i < MAX_DATA_BITS; i++)
         if (i < int'(nb_in)) used[i] = s_if.s_data[i];
      par_on  = (parity >= 3'd1) && (parity <= 3'd4);
      case (parity)
         3'd1:    par_val = ~^used;
         3'd2:    par_val = ^used;
         3'd3:    par_val = 1'b1;
         default: par_val = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tx        <= 1'b1;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
         cnt       <= '0;
         div_l     <= '0;
         nb_l      <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         par_on_l  <= 1'b0;
         par_bit_l <= 1'b0;
         stop2_l   <= 1'b0;
         stop_idx  <= 1'b0;
         brk_rel   <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               if (send_break) begin
                  state   <= BREAK;
                  tx      <= 1'b0;
                  tx_busy <= 1'b1;
                  brk_rel <= 1'b0;
                  cnt     <= '0;
               end else if (accept) begin
                  state     <= START;
                  tx        <= 1'b0;
                  tx_busy   <= 1'b1;
                  cnt       <= '0;
                  div_l     <= div;
                  nb_l      <= nb_in;
                  shreg     <= used;
                  par_on_l  <= par_on;
                  par_bit_l <= par_val;
                  stop2_l   <= stop_bits;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt     <= '0;
                  state   <= DATA;
                  tx      <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_idx <= '0;
               end else cnt <= cnt + DIV_WIDTH'(1);
            end
            DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_idx == nb_l - 4'd1) begin
                     if (par_on_l) begin
                        state <= PARITY;
                        tx    <= par_bit_l;
                     end else begin
                        state    <= STOP;
                        tx       <= 1'b1;
                        stop_idx <= 1'b0;
                     end
                  end else begin
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_idx <= bit_idx + 4'd1;
                  end
               end else cnt <= cnt + DIV_WIDTH'(1);
            end
            PARITY: begin
               if (bit_end) begin
                  cnt      <= '0;
                  state    <= STOP;
                  tx       <= 1'b1;
                  stop_idx <= 1'b0;
               end else cnt <= cnt + DIV_WIDTH'(1);
            end
            STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (stop2_l && !stop_idx) stop_idx <= 1'b1;
                  else begin
                     state   <= IDLE;
                     tx_busy <= 1'b0;
                     tx_done <= 1'b1;
                  end
               end else cnt <= cnt + DIV_WIDTH'(1);
            end
            BREAK: begin
               if (!brk_rel) begin
                  if (!send_break) begin
                     brk_rel <= 1'b1;
                     tx      <= 1'b1;
                     cnt     <= '0;
                  end
               end else if (cnt >= div) begin
                  // The closing idle bit uses the live divisor. Using >= also ends the bit
                  // cleanly if div shrinks while it is being sent.
                  state   <= IDLE;
                  brk_rel <= 1'b0;
                  cnt     <= '0;
                  tx_busy <= 1'b0;
                  tx_done <= 1'b1;
               end else cnt <= cnt + DIV_WIDTH'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param. A table of frame configurations is paired with
// hand-computed line waveforms (bit k of frame = line level during bit period k).
// Hand-written sequences cover break, back-to-back, reset abort and tx_en drop.
module tb_uart_tx_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tx_en;
   logic [15:0] div;
   logic [3:0]  data_bits;
   logic [2:0]  parity;
   logic        stop_bits;
   logic        send_break;
   logic        tx, tx_busy, tx_done;
   int          total = 0;
   int          bad   = 0;

   uart_tx_param_if #(.MAX_DATA_BITS(9)) s_if ();

   uart_tx_param #(.MAX_DATA_BITS(9), .DIV_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .div(div), .data_bits(data_bits),
      .parity(parity), .stop_bits(stop_bits), .send_break(send_break), .s_if(s_if),
      .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [15:0] dv;
      logic [3:0]  nb;
      logic [2:0]  par;
      logic        st;
      logic [8:0]  data;
      logic [15:0] frame;
      int          nbits;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Apply config and payload at a negedge, then wait for the accept edge.
   // Returns #1 after the accept edge (frame cycle 0).
   task automatic do_accept(input logic [15:0] dv, input logic [3:0] nb, input logic [2:0] par,
                            input logic st, input logic [8:0] d, input logic hold);
      int n;
      n = 0;
      @(negedge clk);
      div = dv; data_bits = nb; parity = par; stop_bits = st;
      s_if.s_data = d; s_if.s_valid = 1'b1;
      while (!s_if.s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         total++; bad++;
         $display("FAIL accept_timeout: s_ready never rose, required 1");
      end
      @(posedge clk); #1;
      if (!hold) s_if.s_valid = 1'b0;
   endtask

   // Starting at frame cycle 0: check the line every cycle, then the tx_done cycle.
   task automatic check_frame(input logic [15:0] frame, input int nbits, input int dv, input string id);
      int per;
      per = dv + 1;
      for (int k = 0; k < nbits * per; k++) begin
         chk($sformatf("%s tx c%0d", id, k), tx, frame[k / per]);
         chk($sformatf("%s busy c%0d", id, k), tx_busy, 1'b1);
         chk($sformatf("%s done c%0d", id, k), tx_done, 1'b0);
         @(posedge clk); #1;
      end
      chk($sformatf("%s done end", id), tx_done, 1'b1);
      chk($sformatf("%s tx end", id), tx, 1'b1);
      chk($sformatf("%s busy end", id), tx_busy, 1'b0);
   endtask

   initial begin
      //        div    nb     par   st    data    frame     nbits
      vecs[0] = '{16'd3, 4'd8, 3'd0, 1'b0, 9'h055, 16'h02AA, 10}; // 8N1 0x55
      vecs[1] = '{16'd0, 4'd9, 3'd2, 1'b1, 9'h1FF, 16'h1FFE, 13}; // 9E2
      vecs[2] = '{16'd1, 4'd7, 3'd1, 1'b0, 9'h080, 16'h0300, 10}; // 7O1, bit 7 dropped
      vecs[3] = '{16'd0, 4'd5, 3'd3, 1'b0, 9'h01F, 16'h00FE,  8}; // 5 mark
      vecs[4] = '{16'd0, 4'd5, 3'd4, 1'b0, 9'h01F, 16'h00BE,  8}; // 5 space
      vecs[5] = '{16'd1, 4'hF, 3'd0, 1'b0, 9'h1A5, 16'h034A, 10}; // bad count -> 8 bits
      vecs[6] = '{16'd0, 4'd6, 3'd7, 1'b1, 9'h02D, 16'h01DA,  9}; // bad parity -> none, 2 stop
      vecs[7] = '{16'd2, 4'd8, 3'd1, 1'b0, 9'h003, 16'h0606, 11}; // 8O1

      rst_n = 1'b0; tx_en = 1'b1; div = '0; data_bits = 4'd8; parity = '0;
      stop_bits = 1'b0; send_break = 1'b0; s_if.s_data = '0; s_if.s_valid = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset tx", tx, 1'b1);
      chk("reset busy", tx_busy, 1'b0);
      chk("reset done", tx_done, 1'b0);
      chk("reset ready", s_if.s_ready, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("idle ready", s_if.s_ready, 1'b1);
      chk("idle tx", tx, 1'b1);

      for (int i = 0; i < 8; i++) begin
         do_accept(vecs[i].dv, vecs[i].nb, vecs[i].par, vecs[i].st, vecs[i].data, 1'b0);
         check_frame(vecs[i].frame, vecs[i].nbits, int'(vecs[i].dv), $sformatf("vec%0d", i));
      end

      // Back-to-back: s_valid held, second word presented right after the first accept.
      do_accept(16'd2, 4'd8, 3'd0, 1'b0, 9'h03C, 1'b1);
      s_if.s_data = 9'h0C3;
      check_frame(16'h0278, 10, 2, "b2b_a");
      chk("b2b ready at done", s_if.s_ready, 1'b1);
      @(posedge clk); #1;
      s_if.s_valid = 1'b0;
      check_frame(16'h0386, 10, 2, "b2b_b");
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("b2b no third tx", tx, 1'b1);
         chk("b2b no third busy", tx_busy, 1'b0);
      end

      // Break with a pending word: break wins, 20 low clocks, 4 high, done, then accept.
      @(negedge clk);
      div = 16'd3; data_bits = 4'd8; parity = 3'd0; stop_bits = 1'b0;
      s_if.s_data = 9'h055; s_if.s_valid = 1'b1; send_break = 1'b1;
      #1;
      chk("brk ready low", s_if.s_ready, 1'b0);
      @(posedge clk); #1;
      for (int k = 0; k < 20; k++) begin
         chk($sformatf("brk low c%0d", k), tx, 1'b0);
         chk($sformatf("brk ready c%0d", k), s_if.s_ready, 1'b0);
         chk($sformatf("brk busy c%0d", k), tx_busy, 1'b1);
         if (k == 19) begin
            @(negedge clk); send_break = 1'b0;
         end
         @(posedge clk); #1;
      end
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("brk rel tx c%0d", k), tx, 1'b1);
         chk($sformatf("brk rel done c%0d", k), tx_done, 1'b0);
         chk($sformatf("brk rel ready c%0d", k), s_if.s_ready, 1'b0);
         @(posedge clk); #1;
      end
      chk("brk done", tx_done, 1'b1);
      chk("brk done busy", tx_busy, 1'b0);
      chk("brk pending ready", s_if.s_ready, 1'b1);
      @(posedge clk); #1;
      s_if.s_valid = 1'b0;
      check_frame(16'h02AA, 10, 3, "brk_word");

      // Reset in the middle of the data bits abandons the frame at once.
      do_accept(16'd3, 4'd8, 3'd0, 1'b0, 9'h000, 1'b0);
      repeat (10) begin
         @(posedge clk); #1;
      end
      chk("rst mid data tx", tx, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst async tx", tx, 1'b1);
      chk("rst async busy", tx_busy, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("post rst tx", tx, 1'b1);
         chk("post rst busy", tx_busy, 1'b0);
      end
      chk("post rst ready", s_if.s_ready, 1'b1);

      // tx_en drop plus config changes mid-frame: the frame finishes as latched, no new accept.
      do_accept(16'd0, 4'd8, 3'd0, 1'b0, 9'h00F, 1'b0);
      tx_en = 1'b0; s_if.s_valid = 1'b1; s_if.s_data = 9'h1AA;
      div = 16'd5; data_bits = 4'd5; parity = 3'd2; stop_bits = 1'b1;
      check_frame(16'h021E, 10, 0, "txen");
      chk("txen ready at done", s_if.s_ready, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk("txen idle tx", tx, 1'b1);
         chk("txen idle busy", tx_busy, 1'b0);
         chk("txen idle ready", s_if.s_ready, 1'b0);
      end
      s_if.s_valid = 1'b0;
      tx_en = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
